// File: rtl/adder_pkg.sv
// Shared opcode encodings, FSM state type and flag helpers for the
// multicycle adder.
package adder_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDU = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SUBU = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed overflow from the operand MSBs (B after inversion) and the sum MSB.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    endfunction

    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] && op[1];
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// CHUNK-bit combinational carry-lookahead slice: SUM = A + B + cin,
// C_OUT is the carry out of the slice MSB.
module cla_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             cin,
    output logic [CHUNK-1:0] SUM,
    output logic             C_OUT
);

    logic [CHUNK-1:0] gen;
    logic [CHUNK-1:0] prop;
    logic [CHUNK-1:0] carry;
    logic             acc;

    assign gen  = A & B;
    assign prop = A ^ B;

    // Generate/propagate recurrence kept in a local temporary so the carry
    // terms flatten into lookahead logic without a combinational self-loop.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        carry = '0;
        acc   = cin;
        for (int i = 0; i < CHUNK; i++) begin
            carry[i] = acc;
            acc      = gen[i] | (prop[i] & acc);
        end
    end

    assign SUM   = prop ^ carry;
    assign C_OUT = acc;

endmodule

// File: rtl/adder_multicycle.sv
// Sequential add/sub/inc/dec unit: sums CHUNK bits per clock through a
// registered inter-chunk carry, with a start/busy/done handshake.
module adder_multicycle
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    input  logic             Carryout,
    output logic [WIDTH-1:0] C,
    output logic             overFlag,
    output logic             coutFlag,
    output logic             busy,
    output logic             done
);

    localparam int             N    = WIDTH / CHUNK;
    localparam int             KW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]  LAST = KW'(N - 1);

    state_t state, state_nxt;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] shadow;
    logic             cy;
    logic [2:0]       op_reg;
    logic             sup_reg;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             accept;
    logic             last;
    int               base;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] result_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Done cycles are IDLE, so a start there is accepted with no bubble.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (k == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_comb begin
        a_in = A;
        b_in = B;
        c_in = 1'b0;
        case (control)
            OP_ADD, OP_ADDU: b_in = B;
            OP_SUB, OP_SUBU: begin
                b_in = ~B;
                c_in = 1'b1;
            end
            OP_INC: b_in = WIDTH'(1);
            OP_DEC: begin
                b_in = ~WIDTH'(1);
                c_in = 1'b1;
            end
            default: begin
                a_in = '0;
                b_in = '0;
            end
        endcase
    end

    always_comb base = int'(k) * CHUNK;

    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
        .A     (a_reg[base +: CHUNK]),
        .B     (b_reg[base +: CHUNK]),
        .cin   (cy),
        .SUM   (slice_sum),
        .C_OUT (slice_cout)
    );

    // The last slice goes straight into C so the result lands on the final RUN edge.
    always_comb begin
        result_full                = shadow;
        result_full[base +: CHUNK] = slice_sum;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            shadow   <= '0;
            cy       <= 1'b0;
            op_reg   <= '0;
            sup_reg  <= 1'b0;
            C        <= '0;
            overFlag <= 1'b0;
            coutFlag <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg   <= a_in;
                b_reg   <= b_in;
                cy      <= c_in;
                op_reg  <= control;
                sup_reg <= Carryout;
                k       <= '0;
            end else if (state == RUN) begin
                shadow[base +: CHUNK] <= slice_sum;
                cy                    <= slice_cout;
                k                     <= k + 1'b1;
                if (last) begin
                    C        <= result_full;
                    overFlag <= is_signed_op(op_reg) &&
                                signed_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1],
                                                slice_sum[CHUNK-1]);
                    coutFlag <= !(sup_reg || is_illegal_op(op_reg)) && slice_cout;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_multicycle.sv
// Randomised and directed self-checking bench for adder_multicycle
// (WIDTH=16, CHUNK=4) against an arithmetic reference model.
module tb_adder_multicycle;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] ADDU = 3'd1;
    localparam logic [2:0] SUB  = 3'd2;
    localparam logic [2:0] INC  = 3'd4;
    localparam logic [2:0] DEC  = 3'd5;
    localparam logic [2:0] ILL  = 3'd6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       control;
    logic             Carryout;
    logic [WIDTH-1:0] C;
    logic             overFlag;
    logic             coutFlag;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] exp_c;
    logic             exp_ov;
    logic             exp_co;
    logic [WIDTH-1:0] prev_c;

    adder_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .control  (control),
        .Carryout (Carryout),
        .C        (C),
        .overFlag (overFlag),
        .coutFlag (coutFlag),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: unsigned sum for C/carry, signed-range test for overflow.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic sup,
                         output logic [WIDTH-1:0] c, output logic ov, output logic co);
        int unsigned ain, bin, cin, full;
        int          sa, sb, ss;
        bit          signed_op;
        ain = a;
        cin = 0;
        signed_op = 0;
        case (op)
            3'd0: begin bin = b; signed_op = 1; end
            3'd1: bin = b;
            3'd2: begin bin = 32'hFFFF - b; cin = 1; signed_op = 1; end
            3'd3: begin bin = 32'hFFFF - b; cin = 1; end
            3'd4: begin bin = 1; signed_op = 1; end
            3'd5: begin bin = 32'hFFFE; cin = 1; signed_op = 1; end
            default: begin ain = 0; bin = 0; end
        endcase
        full = ain + bin + cin;
        c    = WIDTH'(full % 65536);
        sa   = (ain >= 32768) ? int'(ain) - 65536 : int'(ain);
        sb   = (bin >= 32768) ? int'(bin) - 65536 : int'(bin);
        ss   = sa + sb + int'(cin);
        ov   = signed_op && (ss > 32767 || ss < -32768);
        co   = (sup || op >= 3'd6) ? 1'b0 : ((full / 65536) != 0);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic sup);
        A        = a;
        B        = b;
        control  = op;
        Carryout = sup;
        start    = 1'b1;
        prev_c   = C;
        model(a, b, op, sup, exp_c, exp_ov, exp_co);
    endtask

    // Called at the negedge where start was raised; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input bit poke);
        int lat;
        int busy_cnt;
        bit held;
        lat      = 0;
        busy_cnt = 0;
        held     = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (C !== prev_c) held = 0;
            A        = WIDTH'($urandom);
            B        = WIDTH'($urandom);
            control  = 3'($urandom);
            Carryout = 1'($urandom);
            start    = (poke && lat == 1);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, ".done_seen"}, done, 1);
        check({tag, ".latency"}, lat, N);
        check({tag, ".busy_cycles"}, busy_cnt, N);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".held"}, held, 1);
        check({tag, ".C"}, C, exp_c);
        check({tag, ".overFlag"}, overFlag, exp_ov);
        check({tag, ".coutFlag"}, coutFlag, exp_co);
    endtask

    initial begin
        int saw;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        start       = 1'b0;
        A           = '0;
        B           = '0;
        control     = '0;
        Carryout    = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset.C", C, 0);
        check("reset.overFlag", overFlag, 0);
        check("reset.coutFlag", coutFlag, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        issue(16'h7FFF, 16'h0001, ADD, 1'b0);
        wait_done("add_ovf", 0);
        @(negedge clk);
        check("add_ovf.done_pulse", done, 0);

        issue(16'hFFFF, 16'h0001, ADDU, 1'b0);
        wait_done("addu_carry", 0);
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, ADDU, 1'b1);
        wait_done("addu_suppress", 0);
        @(negedge clk);

        issue(16'h8000, 16'h0001, SUB, 1'b0);
        wait_done("sub_ovf", 0);
        @(negedge clk);
        issue(16'h0000, 16'h0000, DEC, 1'b0);
        wait_done("dec_zero", 0);
        @(negedge clk);

        // Mid-RUN restart is ignored; start in the done cycle runs back-to-back.
        issue(16'h1234, 16'h0F0F, SUB, 1'b0);
        wait_done("restart_ignored", 1);
        issue(16'h7FFF, 16'h0000, INC, 1'b0);
        wait_done("back_to_back", 0);
        @(negedge clk);

        issue(16'hAAAA, 16'h1111, ADD, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.C", C, 0);
        check("rst_mid.overFlag", overFlag, 0);
        check("rst_mid.coutFlag", coutFlag, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) saw++;
        end
        check("rst_mid.no_done", saw, 0);
        issue(16'h0102, 16'h0304, ADD, 1'b0);
        wait_done("after_rst", 0);
        @(negedge clk);

        issue(16'h1234, 16'h5678, ILL, 1'b0);
        wait_done("illegal", 0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            wait_done("random", 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0) begin
                @(negedge clk);
                check("random.done_pulse", done, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_multicycle.md
Name: adder_multicycle

Overview:
- Parametrised, sequential successor to the 16-bit CLA adder unit.
- Computes add/addu/sub/subu/inc/dec on WIDTH-bit operands, CHUNK bits per clock, with a chunk-to-chunk registered carry.
- Uses a start/busy/done handshake. Result and flags are registered and held until the next completed operation.
- Sits in the ALU datapath beside the logic and shift units; the ALU sequencer drives start and waits for done.

Parameters:
- WIDTH, 16, operand/result width; must be ≥2 and a multiple of CHUNK.
- CHUNK, 4, bits summed per cycle. CHUNK=WIDTH gives single-cycle latency.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE or on a done cycle
- A  input  WIDTH  operand A; latched on accepted start
- B  input  WIDTH  operand B; latched on accepted start
- control  input  3  opcode; latched on accepted start
- Carryout  input  1  coutFlag suppress; latched on accepted start (1 forces coutFlag=0)
- C  output  WIDTH  registered result
- overFlag  output  1  signed overflow of last op
- coutFlag  output  1  raw carry-out of last op, gated by latched Carryout
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; C and flags are valid and updated

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high. On rst: state=IDLE, C=0, overFlag=0, coutFlag=0, busy=0, done=0, internal counter and carry cleared.
- Opcodes (3 bits):
  - 000 add: Bin=B, cin=0.
  - 001 addu: Bin=B, cin=0.
  - 010 sub: Bin=~B, cin=1.
  - 011 subu: Bin=~B, cin=1.
  - 100 inc: Bin=1, cin=0.
  - 101 dec: Bin=~1, cin=1.
  - 110, 111: Ain=Bin=0, cin=0, flags forced 0.
- Arithmetic: Ain is always A. Result is (Ain+Bin+cin) mod 2^WIDTH.
- Raw cout: carry out of MSB. For sub/subu/dec, cout=1 means no borrow.
- overFlag:
  - add/sub/inc/dec: (Ain[MSB]==Bin[MSB]) && (sum[MSB]!=Ain[MSB]), using the post-inversion Bin.
  - addu/subu/illegal opcodes: 0.
- coutFlag = latched Carryout ? 0 : raw cout. Forced 0 for illegal opcodes.
- State machine, with N=WIDTH/CHUNK:
  - IDLE: start=1 → latch Ain, Bin, cin, op, Carryout; chunk index k=0; go to RUN; busy=1 from the next cycle.
  - RUN: each edge adds slice k (CHUNK bits) with the carry register, writes the slice into a shadow result, stores the slice carry, k++. After slice N-1, go to DONE-edge.
  - At that edge: copy shadow to C, compute flags, done=1, busy=0, state=IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge N. Busy is high for exactly N cycles.
- Throughput: start asserted during the done cycle is accepted, giving back-to-back operations with no bubble.
- Start while busy=1 is ignored and not queued. A, B and control changes during RUN have no effect.
- C and flags hold their previous values during RUN; they change only at the done edge.
- rst mid-RUN: immediate clear per the reset values above. No done pulse. The in-flight op is lost.

Decomposition:
- Package adder_pkg holds:
  - opcode localparams OP_ADD=3'b000 … OP_DEC=3'b101;
  - the state encoding IDLE/RUN;
  - a function computing signed-overflow from (a_msb, b_msb, s_msb).
- One sub-module is natural: cla_chunk, a parameterised CHUNK-bit combinational carry-lookahead slice (A, B, cin → SUM, C_OUT). It replaces the fixed cla16bit inside this block.
- The counter, operand registers and flags stay in adder_multicycle.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
- add A=0x7FFF, B=0x0001, Carryout=0 → done 4 cycles after start; C=0x8000, overFlag=1, coutFlag=0; busy high for 4 cycles.
- addu A=0xFFFF, B=0x0001, Carryout=0 → C=0x0000, coutFlag=1, overFlag=0. Repeat with Carryout=1 → coutFlag=0.
- sub A=0x8000, B=0x0001 → C=0x7FFF, overFlag=1, coutFlag=1. Then dec A=0x0000 → C=0xFFFF, overFlag=0, coutFlag=0.
- Handshake: start re-pulsed mid-RUN with different operands → ignored, result unchanged. Start asserted during the done cycle (inc A=0x7FFF) → second done exactly 4 cycles later with C=0x8000, overFlag=1.
- rst asserted 2 cycles into an op → C=0, flags=0, busy=0 asynchronously; no done pulse. A new start afterwards completes normally.
- control=3'b110, A=0x1234, B=0x5678 → done after 4 cycles with C=0x0000, overFlag=0, coutFlag=0.
